multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the RISC-V load-word datapath.
//  Drives the PC, IR, register-file, ALU and shared memory controls one step per state.
//  Supports lw, sw and I-type ALU instructions; flags illegal opcodes.
//  Sits between the instruction register (op/funct3) and the datapath muxes/enables.
//  Handles single-port memory latency through a ready handshake.
// PARAMETERS
//  RET_W  32  width of retired-instruction counter
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  op           in   7   instr[6:0] from IR
//  funct3       in   3   instr[14:12] from IR
//  mem_ready    in   1   memory completes the current read/write this cycle
//  PCWrite      out  1   load PC <- ALUResult (PC+4)
//  IRWrite      out  1   load IR/OldPC from memory read data
//  AdrSrc       out  1   0 = PC, 1 = ALUOut to memory address
//  MemRead      out  1   memory read request
//  MemWrite     out  1   memory write request (WD = RD2)
//  RegWrite     out  1   register-file write enable (A3 = instr[11:7])
//  ALUSrcA      out  2   00 = PC, 01 = OldPC, 10 = RD1
//  ALUSrcB      out  2   00 = RD2, 01 = ImmExt, 10 = const 4
//  ALUControl   out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//  ResultSrc    out  2   00 = ALUOut, 01 = ReadData, 10 = ALUResult
//  illegal      out  1   one-cycle pulse on an unsupported instruction
//  retired      out  RET_W  count of completed instructions
//  state_dbg    out  4   current state encoding
// BEHAVIOUR
//  Reset (rst = 0, async): state = IDLE, retired = 0; every output is 0 while in IDLE.
//  Outputs are decoded from the state. The only exception: FETCH IRWrite/PCWrite = mem_ready.
//  Unlisted outputs are 0 in each state.
//  IDLE     : -> FETCH unconditionally (one cycle after reset release).
//  FETCH    : MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
//             Hold until mem_ready=1, then -> DECODE.
//  DECODE   : ALUSrcA=01, ALUSrcB=01, add.
//             op=0000011 & funct3=010 -> MEMADR (lw).
//             op=0100011 & funct3=010 -> MEMADR (sw).
//             op=0010011 & funct3 in {000,010,110,111} -> EXECI.
//             else -> ILLEGAL.
//  MEMADR   : ALUSrcA=10, ALUSrcB=01, add. Latched op selects next: lw -> MEMRD, sw -> MEMWR.
//  MEMRD    : MemRead=1, AdrSrc=1. Hold until mem_ready, then -> MEMWB.
//  MEMWB    : ResultSrc=01, RegWrite=1, retired++. -> FETCH.
//  MEMWR    : MemWrite=1, AdrSrc=1. Hold until mem_ready, then retired++ -> FETCH.
//  EXECI    : ALUSrcA=10, ALUSrcB=01.
//             ALUControl from funct3: 000 -> add, 010 -> slt, 110 -> or, 111 -> and. -> ALUWB.
//  ALUWB    : ResultSrc=00, RegWrite=1, retired++. -> FETCH.
//  ILLEGAL  : illegal=1 for exactly one cycle, no register/memory write, not counted. -> FETCH.
//  op/funct3 are sampled into an internal register in DECODE.
//    Later states use the latched copy, never live IR bits.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  Request signals stay asserted and stable while waiting; wait length is unbounded.
//  retired wraps from 2^RET_W-1 to 0 with no flag.
//  Reset asserted mid-instruction: outputs drop to 0 asynchronously.
//    The pending memory access is abandoned and there is no partial write-back.
//  Minimum latency with mem_ready tied 1:
//    lw = 5 cycles, sw = 4, I-ALU = 4, illegal = 3 (FETCH to next FETCH).
// STRUCTURE
//  Package multicycle_ctrl_pkg holds:
//    state encoding (IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6,
//      EXECI=7, ALUWB=8, ILLEGAL=9);
//    opcode constants OP_LW, OP_SW, OP_ITYPE;
//    ALUSrcA/ALUSrcB/ResultSrc/ALUControl codes.
//  Sub-module multicycle_alu_dec: combinational map from state/funct3 to ALUControl.
//  FSM register, op latch and retired counter stay in the top.
// TESTING
//  1. Reset low for 3 cycles, release -> all outputs 0 in IDLE; FETCH on the next cycle; retired = 0.
//  2. lw x5,8(x2) (0x00812283), mem_ready=1 ->
//       state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB;
//       RegWrite=1 with ResultSrc=01 in cycle 5; retired = 1.
//  3. Same lw, mem_ready held 0 for 4 cycles in FETCH and 3 in MEMRD ->
//       MemRead held high throughout, no early IRWrite, total 12 cycles.
//  4. sw x6,4(x2) (0x00612223) -> MemWrite=1 with AdrSrc=1 until mem_ready; RegWrite never 1.
//  5. ori x1,x0,5 (0x00506093) -> ALUControl=011 in EXECI, RegWrite in ALUWB;
//     andi with funct3=111 -> ALUControl=010.
//  6. Opcode 0x33 (R-type) -> illegal pulses exactly 1 cycle, retired unchanged.
//     Then assert rst in MEMRD of the next lw -> immediate all-0 outputs, state IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control sequencer.
// Covers state codes, opcodes, mux select codes and the DECODE dispatch helper.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLTI = 3'b010;
  localparam logic [2:0] F3_ORI  = 3'b110;
  localparam logic [2:0] F3_ANDI = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Successor of DECODE for a given instruction; anything unsupported traps to ILLEGAL.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] funct3);
    state_t nxt;
    nxt = S_ILLEGAL;
    if ((op == OP_LW || op == OP_SW) && funct3 == F3_WORD)
      nxt = S_MEMADR;
    else if (op == OP_ITYPE &&
             (funct3 == F3_ADDI || funct3 == F3_SLTI ||
              funct3 == F3_ORI  || funct3 == F3_ANDI))
      nxt = S_EXECI;
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction-register inputs, memory handshake and datapath controls of the sequencer.
// The slave modport is the controller side; the master modport is the datapath side.
interface multicycle_ctrl_fsm_if #(
  parameter int RET_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             AdrSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [1:0]       ResultSrc;
  logic             illegal;
  logic [RET_W-1:0] retired;
  logic [3:0]       state_dbg;

  modport slave (
    input  op, funct3, mem_ready,
    output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, illegal, retired, state_dbg
  );

  modport master (
    output op, funct3, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, illegal, retired, state_dbg
  );
endinterface

// File: rtl/multicycle_alu_dec.sv
// ALU operation select: add everywhere except EXECI, where the latched funct3 picks the op.
module multicycle_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    if (i_state == S_EXECI) begin
      case (i_funct3)
        F3_SLTI: o_alu_ctrl = ALU_SLT;
        F3_ORI:  o_alu_ctrl = ALU_OR;
        F3_ANDI: o_alu_ctrl = ALU_AND;
        default: o_alu_ctrl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for lw/sw/I-type ALU instructions with a ready-paced memory.
// State register, instruction-field latch and retired-instruction counter live here.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int RET_W = 32
)(
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_fsm_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [6:0]       r_op;
  logic [2:0]       r_funct3;
  logic [RET_W-1:0] r_retired;
  logic             w_retire;
  logic [2:0]       w_alu_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Later states must not see IR bits that change after DECODE.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) begin
      r_op     <= bus.op;
      r_funct3 <= bus.funct3;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = S_FETCH;
      S_FETCH:   w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next_state = decode_next(bus.op, bus.funct3);
      S_MEMADR:  w_next_state = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR:   w_next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECI:   w_next_state = S_ALUWB;
      S_ALUWB:   w_next_state = S_FETCH;
      S_ILLEGAL: w_next_state = S_FETCH;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RD2;
    bus.ResultSrc = RES_ALUOUT;
    bus.illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.MemRead   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        // IR and PC load only on the cycle the read data is actually valid.
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_READDATA;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
      end
      S_ILLEGAL: bus.illegal = 1'b1;
      default: ;
    endcase
  end

  multicycle_alu_dec u_alu_dec (
    .i_state    (r_state),
    .i_funct3   (r_funct3),
    .o_alu_ctrl (w_alu_ctrl)
  );

  // A store retires on the cycle memory accepts it, not on entry to MEMWR.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    ((r_state == S_MEMWR) && bus.mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + RET_W'(1);
  end

  assign bus.ALUControl = w_alu_ctrl;
  assign bus.retired    = r_retired;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for the multi-cycle control sequencer with hand-computed control words.
module tb_multicycle_ctrl_fsm;

  localparam int RET_W = 3;

  // Control word order: PCWrite,IRWrite,AdrSrc,MemRead,MemWrite,RegWrite,ALUSrcA,ALUSrcB,ALUControl,ResultSrc,illegal
  localparam logic [15:0] E_IDLE      = 16'h0000;
  localparam logic [15:0] E_FETCH_W   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,3'b000,2'b10,1'b0};
  localparam logic [15:0] E_FETCH_R   = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,3'b000,2'b10,1'b0};
  localparam logic [15:0] E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,3'b000,2'b00,1'b0};
  localparam logic [15:0] E_MEMADR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,3'b000,2'b00,1'b0};
  localparam logic [15:0] E_MEMRD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,3'b000,2'b00,1'b0};
  localparam logic [15:0] E_MEMWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,2'b01,1'b0};
  localparam logic [15:0] E_MEMWR     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,2'b00,1'b0};
  localparam logic [15:0] E_EXECI_OR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,3'b011,2'b00,1'b0};
  localparam logic [15:0] E_EXECI_AND = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,3'b010,2'b00,1'b0};
  localparam logic [15:0] E_ALUWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,2'b00,1'b0};
  localparam logic [15:0] E_ILLEGAL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,2'b00,1'b1};

  localparam logic [31:0] I_LW   = 32'h0081_2283;
  localparam logic [31:0] I_SW   = 32'h0061_2223;
  localparam logic [31:0] I_ORI  = 32'h0050_6093;
  localparam logic [31:0] I_ANDI = 32'h0050_7093;
  localparam logic [31:0] I_RTYP = 32'h0000_0033;
  localparam logic [31:0] I_SLLI = 32'h0010_1093;
  localparam logic [31:0] I_LB   = 32'h0001_0283;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [RET_W-1:0] exp_ret = '0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.RET_W(RET_W)) bus ();

  multicycle_ctrl_fsm #(.RET_W(RET_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] ctl();
    return {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemRead, bus.MemWrite, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc, bus.illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic mr);
    bus.op        = instr[6:0];
    bus.funct3    = instr[14:12];
    bus.mem_ready = mr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(32'h0, 1'b0);
    repeat (3) tick();
    n_cmp++;
    if (bus.state_dbg !== 4'd0 || ctl() !== E_IDLE || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d ctl=%h retired=%0d, want state=0 ctl=%h retired=%0d",
               bus.state_dbg, ctl(), bus.retired, E_IDLE, exp_ret);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.state_dbg !== 4'd0 || ctl() !== E_IDLE) begin
      n_err++;
      $display("FAIL reset_idle: state=%0d ctl=%h, want state=0 ctl=%h", bus.state_dbg, ctl(), E_IDLE);
    end
    tick();
    n_cmp++;
    if (bus.state_dbg !== 4'd1 || ctl() !== E_FETCH_W || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL reset_fetch: state=%0d ctl=%h retired=%0d, want state=1 ctl=%h retired=%0d",
               bus.state_dbg, ctl(), bus.retired, E_FETCH_W, exp_ret);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  es [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [15:0] ec [5] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    for (int i = 0; i < 5; i++) begin
      drive((i < 2) ? I_LW : I_RTYP, 1'b1);
      #1;
      n_cmp++;
      if (bus.state_dbg !== es[i] || ctl() !== ec[i]) begin
        n_err++;
        $display("FAIL lw[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, bus.state_dbg, ctl(), es[i], ec[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 1'b1;
    n_cmp++;
    if (bus.state_dbg !== 4'd1 || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL lw_end: state=%0d retired=%0d, want state=1 retired=%0d",
               bus.state_dbg, bus.retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait();
    logic [0:11] mr = 12'b000011100010;
    logic [3:0]  es [12] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
    logic [15:0] ec [12] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE,
                             E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
    for (int i = 0; i < 12; i++) begin
      drive((i < 6) ? I_LW : I_RTYP, mr[i]);
      #1;
      n_cmp++;
      if (bus.state_dbg !== es[i] || ctl() !== ec[i]) begin
        n_err++;
        $display("FAIL lw_wait[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, bus.state_dbg, ctl(), es[i], ec[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 1'b1;
    n_cmp++;
    if (bus.state_dbg !== 4'd1 || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL lw_wait_end: state=%0d retired=%0d, want state=1 retired=%0d",
               bus.state_dbg, bus.retired, exp_ret);
    end
  endtask

  task automatic test_sw();
    logic [0:5]  mr = 6'b100001;
    logic [3:0]  es [6] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6};
    logic [15:0] ec [6] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR};
    for (int i = 0; i < 6; i++) begin
      drive((i < 2) ? I_SW : I_LW, mr[i]);
      #1;
      n_cmp++;
      if (bus.state_dbg !== es[i] || ctl() !== ec[i] || bus.retired !== exp_ret) begin
        n_err++;
        $display("FAIL sw[%0d]: state=%0d ctl=%h retired=%0d, want state=%0d ctl=%h retired=%0d",
                 i, bus.state_dbg, ctl(), bus.retired, es[i], ec[i], exp_ret);
      end
      tick();
    end
    exp_ret = exp_ret + 1'b1;
    n_cmp++;
    if (bus.state_dbg !== 4'd1 || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL sw_end: state=%0d retired=%0d, want state=1 retired=%0d",
               bus.state_dbg, bus.retired, exp_ret);
    end
  endtask

  task automatic test_itype();
    logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
    logic [15:0] ec [4];
    logic [31:0] instr;
    for (int k = 0; k < 2; k++) begin
      instr = (k == 0) ? I_ORI : I_ANDI;
      ec = '{E_FETCH_R, E_DECODE, (k == 0) ? E_EXECI_OR : E_EXECI_AND, E_ALUWB};
      for (int i = 0; i < 4; i++) begin
        drive((i < 2) ? instr : I_RTYP, 1'b1);
        #1;
        n_cmp++;
        if (bus.state_dbg !== es[i] || ctl() !== ec[i]) begin
          n_err++;
          $display("FAIL itype%0d[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h",
                   k, i, bus.state_dbg, ctl(), es[i], ec[i]);
        end
        tick();
      end
      exp_ret = exp_ret + 1'b1;
      n_cmp++;
      if (bus.state_dbg !== 4'd1 || bus.retired !== exp_ret) begin
        n_err++;
        $display("FAIL itype%0d_end: state=%0d retired=%0d, want state=1 retired=%0d",
                 k, bus.state_dbg, bus.retired, exp_ret);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3] = '{I_RTYP, I_SLLI, I_LB};
    logic [3:0]  es [3]  = '{4'd1, 4'd2, 4'd9};
    logic [15:0] ec [3]  = '{E_FETCH_R, E_DECODE, E_ILLEGAL};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive(bad[k], 1'b1);
        #1;
        n_cmp++;
        if (bus.state_dbg !== es[i] || ctl() !== ec[i]) begin
          n_err++;
          $display("FAIL illegal%0d[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h",
                   k, i, bus.state_dbg, ctl(), es[i], ec[i]);
        end
        tick();
      end
      n_cmp++;
      if (bus.state_dbg !== 4'd1 || bus.illegal !== 1'b0 || bus.retired !== exp_ret) begin
        n_err++;
        $display("FAIL illegal%0d_end: state=%0d illegal=%b retired=%0d, want state=1 illegal=0 retired=%0d",
                 k, bus.state_dbg, bus.illegal, bus.retired, exp_ret);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 3; k++) begin
      drive(I_ORI, 1'b1);
      repeat (4) tick();
      exp_ret = exp_ret + 1'b1;
      n_cmp++;
      if (bus.state_dbg !== 4'd1 || bus.retired !== exp_ret) begin
        n_err++;
        $display("FAIL wrap[%0d]: state=%0d retired=%0d, want state=1 retired=%0d",
                 k, bus.state_dbg, bus.retired, exp_ret);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(I_LW, 1'b1);
    tick();
    tick();
    drive(I_LW, 1'b0);
    tick();
    #1;
    n_cmp++;
    if (bus.state_dbg !== 4'd4 || ctl() !== E_MEMRD) begin
      n_err++;
      $display("FAIL rst_mid_pre: state=%0d ctl=%h, want state=4 ctl=%h", bus.state_dbg, ctl(), E_MEMRD);
    end
    rst = 1'b0;
    #1;
    exp_ret = '0;
    n_cmp++;
    if (bus.state_dbg !== 4'd0 || ctl() !== E_IDLE || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL rst_mid_async: state=%0d ctl=%h retired=%0d, want state=0 ctl=%h retired=0",
               bus.state_dbg, ctl(), bus.retired, E_IDLE);
    end
    bus.mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.state_dbg !== 4'd0 || ctl() !== E_IDLE) begin
      n_err++;
      $display("FAIL rst_mid_hold: state=%0d ctl=%h, want state=0 ctl=%h", bus.state_dbg, ctl(), E_IDLE);
    end
    bus.mem_ready = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.state_dbg !== 4'd1 || ctl() !== E_FETCH_W || bus.retired !== exp_ret) begin
      n_err++;
      $display("FAIL rst_mid_refetch: state=%0d ctl=%h retired=%0d, want state=1 ctl=%h retired=0",
               bus.state_dbg, ctl(), bus.retired, E_FETCH_W);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lw_wait();
    test_sw();
    test_itype();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
